// File: rtl/iq_out_drain.sv
// Drain stage for the IQ interpolator output FIFO pair: sizes the run from
// sig_len/ilen, pops I/Q pairs and writes them to Y memory at sequential addresses.
module iq_out_drain #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  nop_i,
    input  logic [ADDR_WIDTH-1:0] sig_len_i,
    input  logic [ADDR_WIDTH-1:0] ilen_i,
    input  logic                  Empty_i,
    input  logic [DATA_WIDTH-1:0] data_I_i,
    input  logic [DATA_WIDTH-1:0] data_Q_i,
    output logic                  Read_Enable_o,
    output logic                  Write_Enable_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_I_o,
    output logic [DATA_WIDTH-1:0] data_Q_o,
    output logic [ADDR_WIDTH-1:0] total_len_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  len_err_o
);

    localparam int unsigned PROD_WIDTH = 2 * ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] total_q, total_d;
    logic [DATA_WIDTH-1:0] data_i_q, data_i_d;
    logic [DATA_WIDTH-1:0] data_q_q, data_q_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [PROD_WIDTH-1:0] prod;
    logic                  sig_short;
    logic                  prod_ovf;
    logic                  prod_zero;
    logic                  rd_en_c;
    logic                  last_wr;

    // Run length: ilen * (sig_len - 2), computed at double width to catch overflow
    assign prod      = PROD_WIDTH'(ilen_i) * PROD_WIDTH'(sig_len_i - ADDR_WIDTH'(2));
    assign sig_short = (sig_len_i < ADDR_WIDTH'(2));
    assign prod_ovf  = |prod[PROD_WIDTH-1:ADDR_WIDTH];
    assign prod_zero = (prod[ADDR_WIDTH-1:0] == '0);

    assign rd_en_c = (state_q == S_RUN) && !Empty_i && !nop_i && (rd_cnt_q < total_q);
    assign last_wr = we_q && (addr_q == total_q - ADDR_WIDTH'(1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            addr_q    <= '0;
            total_q   <= '0;
            data_i_q  <= '0;
            data_q_q  <= '0;
            rd_pend_q <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            addr_q    <= addr_d;
            total_q   <= total_d;
            data_i_q  <= data_i_d;
            data_q_q  <= data_q_d;
            rd_pend_q <= rd_pend_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (sig_short || prod_ovf || prod_zero) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_wr) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; a read issued now lands as a write two cycles later
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        addr_d    = addr_q;
        total_d   = total_q;
        data_i_d  = data_i_q;
        data_q_d  = data_q_q;
        err_d     = err_q;
        rd_pend_d = rd_en_c;
        we_d      = 1'b0;
        busy_d    = (state_d == S_CALC) || (state_d == S_RUN);
        done_d    = (state_d == S_DONE);

        if (state_q == S_CALC) begin
            rd_cnt_d  = '0;
            wr_cnt_d  = '0;
            rd_pend_d = 1'b0;
            err_d     = 1'b0;
            total_d   = '0;
            if (!sig_short) begin
                if (prod_ovf) begin
                    err_d = 1'b1;
                end else begin
                    total_d = prod[ADDR_WIDTH-1:0];
                end
            end
        end

        if (rd_en_c) begin
            rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
        end

        if (rd_pend_q) begin
            data_i_d = data_I_i;
            data_q_d = data_Q_i;
            addr_d   = wr_cnt_q;
            we_d     = 1'b1;
            wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
        end
    end

    assign Read_Enable_o  = rd_en_c;
    assign Write_Enable_o = we_q;
    assign addr_o         = addr_q;
    assign data_I_o       = data_i_q;
    assign data_Q_o       = data_q_q;
    assign total_len_o    = total_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign len_err_o      = err_q;

endmodule

// File: tb/tb_iq_out_drain.sv
// Scoreboard bench for iq_out_drain: a FIFO model feeds random I/Q data, expected
// writes are queued per run from the length rule, and a monitor checks every write.
`timescale 1ns/1ps
module tb_iq_out_drain;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 20;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        logic [DW-1:0] dq;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          nop_i;
    logic [AW-1:0] sig_len_i;
    logic [AW-1:0] ilen_i;
    logic          Empty_i;
    logic [DW-1:0] data_I_i;
    logic [DW-1:0] data_Q_i;
    logic          Read_Enable_o;
    logic          Write_Enable_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_I_o;
    logic [DW-1:0] data_Q_o;
    logic [AW-1:0] total_len_o;
    logic          busy_o;
    logic          done_o;
    logic          len_err_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    wr_t           exp_q[$];
    logic [DW-1:0] fi[$];
    logic [DW-1:0] fq[$];
    int            empty_mode = 0;
    bit            pause = 1'b0;
    bit            pop_pend = 1'b0;
    int            rd_seen = 0;
    int            wr_seen = 0;
    int            last_we_cyc = -10;
    int            nop_cnt = 0;

    iq_out_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .nop_i         (nop_i),
        .sig_len_i     (sig_len_i),
        .ilen_i        (ilen_i),
        .Empty_i       (Empty_i),
        .data_I_i      (data_I_i),
        .data_Q_i      (data_Q_i),
        .Read_Enable_o (Read_Enable_o),
        .Write_Enable_o(Write_Enable_o),
        .addr_o        (addr_o),
        .data_I_o      (data_I_o),
        .data_Q_o      (data_Q_o),
        .total_len_o   (total_len_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .len_err_o     (len_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: pops on Read_Enable_o, data presented the following cycle
    initial begin
        Empty_i  = 1'b1;
        nop_i    = 1'b0;
        data_I_i = '0;
        data_Q_i = '0;
        forever begin
            @(negedge clk);
            if (pop_pend && fi.size() > 0) begin
                data_I_i = fi.pop_front();
                data_Q_i = fq.pop_front();
            end
            pop_pend = 1'b0;
            nop_i    = pause;
            case (empty_mode)
                0:       Empty_i = (fi.size() == 0);
                1:       Empty_i = (fi.size() == 0) || cyc[0];
                default: Empty_i = (fi.size() == 0) || ($urandom_range(0, 2) == 0);
            endcase
            #1;
            if (Read_Enable_o) begin
                pop_pend = 1'b1;
                rd_seen++;
            end
        end
    end

    // Monitor: compares every Y-memory write against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            nop_cnt = nop_i ? nop_cnt + 1 : 0;
            if (Read_Enable_o) check("re_gating", 64'({nop_i, Empty_i}), 64'd0);
            if (done_o) check("busy_with_done", 64'(busy_o), 64'd0);
            if (Write_Enable_o) begin
                wr_t e;
                wr_seen++;
                last_we_cyc = cyc;
                check("write_while_paused", 64'(nop_cnt >= 3), 64'd0);
                check("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(addr_o), 64'(e.addr));
                    check("wr_data_i", 64'(data_I_o), 64'(e.di));
                    check("wr_data_q", 64'(data_Q_o), 64'(e.dq));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    // Reference: total = ilen*(sig_len-2), 0 for short signals, error when it exceeds AW bits
    task automatic start_run(input int sig, input int il, input int mode, output longint tot);
        longint raw;
        bit     err;
        raw = (sig < 2) ? 0 : longint'(il) * longint'(sig - 2);
        err = (raw >= (longint'(1) << AW));
        tot = err ? 0 : raw;
        fi.delete();
        fq.delete();
        exp_q.delete();
        for (int k = 0; k < tot + 4; k++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            wr_t           e;
            a = DW'($urandom);
            b = DW'($urandom);
            fi.push_back(a);
            fq.push_back(b);
            if (k < tot) begin
                e.addr = AW'(k);
                e.di   = a;
                e.dq   = b;
                exp_q.push_back(e);
            end
        end
        rd_seen    = 0;
        wr_seen    = 0;
        empty_mode = mode;
        sig_len_i  = AW'(sig);
        ilen_i     = AW'(il);
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        check("calc_busy", 64'(busy_o), 64'd1);
        check("calc_done", 64'(done_o), 64'd0);
        step();
        check("total_len", 64'(total_len_o), 64'(tot));
        check("len_err", 64'(len_err_o), 64'(err));
        check("early_done", 64'(done_o), 64'(tot == 0));
    endtask

    task automatic wait_done(input longint tot, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            step();
            n++;
        end
        check("done_reached", 64'(done_o), 64'd1);
        if (tot > 0 && done_o) check("done_after_last_we", 64'(cyc - last_we_cyc), 64'd1);
        repeat (3) step();
        check("write_count", 64'(wr_seen), 64'(tot));
        check("read_count", 64'(rd_seen), 64'(tot));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("done_hold", 64'({done_o, busy_o, Write_Enable_o, Read_Enable_o}), 64'b1000);
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wr_seen < n && k < budget) begin
            step();
            k++;
        end
        check("writes_reached", 64'(wr_seen >= n), 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({Read_Enable_o, Write_Enable_o, busy_o, done_o, len_err_o}), 64'd0);
        check({name, "_addr_total"}, 64'({addr_o, total_len_o}), 64'd0);
        check({name, "_data"}, 64'({data_I_o, data_Q_o}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint tot;
        int     snap;
        rst       = 1'b1;
        start_i   = 1'b0;
        sig_len_i = '0;
        ilen_i    = '0;
        repeat (3) step();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        step();
        check_all_zero("idle_outputs");

        // Basic run, then alternating-empty run
        start_run(10, 10, 0, tot);
        wait_done(tot, 500);
        start_run(10, 10, 1, tot);
        wait_done(tot, 1000);

        // Random lengths with random empty stalls
        for (int r = 0; r < 4; r++) begin
            start_run(int'($urandom_range(2, 12)), int'($urandom_range(1, 9)), 2, tot);
            wait_done(tot, 2000);
        end

        // Pause mid-run for 1000 cycles
        start_run(10, 10, 0, tot);
        wait_writes(20, 200);
        pause = 1'b1;
        repeat (3) step();
        snap = wr_seen;
        repeat (997) step();
        check("no_writes_paused", 64'(wr_seen), 64'(snap));
        pause = 1'b0;
        wait_done(tot, 500);

        // Degenerate and overflow lengths
        start_run(2, 10, 0, tot);
        wait_done(tot, 10);
        start_run(1, 10, 0, tot);
        wait_done(tot, 10);
        start_run(5, 1 << 19, 0, tot);
        wait_done(tot, 10);

        // Reset mid-run, then a fresh run from address 0
        start_run(10, 10, 0, tot);
        wait_writes(30, 200);
        rst = 1'b1;
        step();
        check_all_zero("midrun_reset");
        exp_q.delete();
        fi.delete();
        fq.delete();
        rst  = 1'b0;
        snap = wr_seen;
        repeat (10) step();
        check("no_writes_after_reset", 64'(wr_seen), 64'(snap));
        start_run(10, 10, 0, tot);
        wait_done(tot, 500);

        // start_i ignored during RUN, honoured in DONE
        start_run(10, 10, 1, tot);
        wait_writes(20, 200);
        sig_len_i = AW'(10);
        ilen_i    = AW'(4);
        start_i   = 1'b1;
        step();
        start_i = 1'b0;
        check("restart_in_run_busy", 64'(busy_o), 64'd1);
        wait_done(tot, 1000);
        check("restart_in_run_total", 64'(total_len_o), 64'd80);
        start_run(10, 4, 0, tot);
        wait_done(tot, 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
